// File: rtl/car_motion_ctrl.sv
// rtl/car_motion_ctrl.sv - elevator car motion controller: call latching, floor-by-floor travel, door handshake
//
// Ports:
//   clk, reset (sync, active-high), enable (clock enable; 0 holds all state)
//   doorState          1 = door OPEN, 0 = CLOSE, read back from the door controller
//   internalButton     cabin buttons; [7:1] floor calls, [9:8] open/close (handled by the door side)
//   upButton/downButton hall calls; upButton[7] and downButton[1] do not exist physically
//   currentFloor       1..7
//   currentDirection   STOP=00, UP=10, DOWN=01
//   currentFloorButton {upPend, downPend} at the current floor
//   moving             high while travelling; holds the door controller in reset
//   cabPend/upPend/downPend latched calls
module car_motion_ctrl #(
    parameter int CLK_PER_FLOOR = 1000000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       doorState,
    input  logic [9:1] internalButton,
    input  logic [7:1] upButton,
    input  logic [7:1] downButton,
    output logic [2:0] currentFloor,
    output logic [1:0] currentDirection,
    output logic [1:0] currentFloorButton,
    output logic       moving,
    output logic [7:1] cabPend,
    output logic [7:1] upPend,
    output logic [7:1] downPend
);
    localparam logic [1:0]  DIR_STOP = 2'b00;
    localparam logic [1:0]  DIR_UP   = 2'b10;
    localparam logic [1:0]  DIR_DOWN = 2'b01;
    localparam logic [31:0] TRAVEL   = 32'(CLK_PER_FLOOR);

    typedef enum logic [1:0] {IDLE, MOVE, DOOR_OPEN, DOOR_CLOSE} state_t;
    state_t state, state_next;

    // Call vectors are indexed by floor number; bit 0 has no floor and stays 0.
    logic [7:0]  cab_q, up_q, down_q;
    logic [7:0]  cab_d, up_d, down_d;
    logic [2:0]  floor_q, floor_d;
    logic [1:0]  dir_q, dir_d;
    logic [31:0] count_q, count_d;

    logic [7:0] any_q, here_hot, arrive_hot, clear_hot;
    logic [2:0] arrive_floor;
    logic [1:0] idle_dir, choice_dir;
    logic       here, above, below, door_clear;
    logic       stop_cab, stop_dir, stop_hall, further;

    logic unused_buttons;
    assign unused_buttons = &{1'b0, internalButton[9:8], upButton[7], downButton[1]};

    function automatic logic [7:0] onehot(input logic [2:0] f);
        return 8'd1 << f;
    endfunction

    function automatic logic [7:0] mask_above(input logic [2:0] f);
        case (f)
            3'd0:    return 8'hFE;
            3'd1:    return 8'hFC;
            3'd2:    return 8'hF8;
            3'd3:    return 8'hF0;
            3'd4:    return 8'hE0;
            3'd5:    return 8'hC0;
            3'd6:    return 8'h80;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [7:0] mask_below(input logic [2:0] f);
        return onehot(f) - 8'd1;
    endfunction

    // Request summaries used by both the idle decision and the arrival check.
    always_comb begin
        any_q    = cab_q | up_q | down_q;
        here_hot = onehot(floor_q);
        here     = |(any_q & here_hot);
        above    = |(any_q & mask_above(floor_q));
        below    = |(any_q & mask_below(floor_q));

        // Clamped so the car can never step outside 1..7.
        arrive_floor = floor_q;
        if (dir_q == DIR_UP && floor_q != 3'd7) begin
            arrive_floor = floor_q + 3'd1;
        end else if (dir_q == DIR_DOWN && floor_q != 3'd1) begin
            arrive_floor = floor_q - 3'd1;
        end
        arrive_hot = onehot(arrive_floor);
        stop_cab   = |(cab_q & arrive_hot);
        stop_dir   = (dir_q == DIR_UP) ? |(up_q & arrive_hot) : |(down_q & arrive_hot);
        stop_hall  = |((up_q | down_q) & arrive_hot);
        further    = (dir_q == DIR_UP) ? |(any_q & mask_above(arrive_floor))
                                       : |(any_q & mask_below(arrive_floor));

        if (dir_q != DIR_STOP && (|(cab_q & here_hot) ||
                ((dir_q == DIR_UP) ? |(up_q & here_hot) : |(down_q & here_hot)))) begin
            idle_dir = dir_q;
        end else if (|(up_q & here_hot)) begin
            idle_dir = DIR_UP;
        end else if (|(down_q & here_hot)) begin
            idle_dir = DIR_DOWN;
        end else begin
            idle_dir = (floor_q == 3'd7) ? DIR_DOWN : DIR_UP;
        end

        case (dir_q)
            DIR_UP:   choice_dir = above ? DIR_UP : DIR_DOWN;
            DIR_DOWN: choice_dir = below ? DIR_DOWN : DIR_UP;
            default:  choice_dir = above ? DIR_UP : DIR_DOWN;
        endcase

        // Clearing beats a simultaneous press on the same bit.
        door_clear = (state == DOOR_OPEN || state == DOOR_CLOSE) && doorState;
        clear_hot  = door_clear ? here_hot : 8'h00;
        cab_d  = (cab_q  | {internalButton[7:1], 1'b0}) & ~clear_hot;
        up_d   = (up_q   | {1'b0, upButton[6:1], 1'b0}) & ~((dir_q == DIR_UP)   ? clear_hot : 8'h00);
        down_d = (down_q | {downButton[7:2], 2'b00})    & ~((dir_q == DIR_DOWN) ? clear_hot : 8'h00);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else if (enable) begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        floor_d    = floor_q;
        dir_d      = dir_q;
        count_d    = count_q;
        case (state)
            IDLE: begin
                if (here) begin
                    dir_d      = idle_dir;
                    state_next = DOOR_OPEN;
                end else if (above || below) begin
                    dir_d      = choice_dir;
                    count_d    = TRAVEL;
                    state_next = MOVE;
                end else begin
                    dir_d = DIR_STOP;
                end
            end
            MOVE: begin
                if (count_q == 32'd1) begin
                    floor_d = arrive_floor;
                    if (stop_cab || stop_dir) begin
                        state_next = DOOR_OPEN;
                    end else if (!further && stop_hall) begin
                        // Only the opposite hall call is waiting here: turn around to serve it.
                        dir_d      = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
                        state_next = DOOR_OPEN;
                    end else if (!further) begin
                        state_next = IDLE;
                    end else begin
                        count_d = TRAVEL;
                    end
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            DOOR_OPEN: begin
                if (doorState) begin
                    state_next = DOOR_CLOSE;
                end
            end
            DOOR_CLOSE: begin
                if (!doorState) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            floor_q <= 3'd1;
            dir_q   <= DIR_STOP;
            count_q <= 32'd0;
            cab_q   <= 8'h00;
            up_q    <= 8'h00;
            down_q  <= 8'h00;
        end else if (enable) begin
            floor_q <= floor_d;
            dir_q   <= dir_d;
            count_q <= count_d;
            cab_q   <= cab_d;
            up_q    <= up_d;
            down_q  <= down_d;
        end
    end

    always_comb begin
        moving             = (state == MOVE);
        currentFloor       = floor_q;
        currentDirection   = dir_q;
        currentFloorButton = {|(up_q & here_hot), |(down_q & here_hot)};
        cabPend            = cab_q[7:1];
        upPend             = up_q[7:1];
        downPend           = down_q[7:1];
    end
endmodule

// File: tb/tb_car_motion_ctrl.sv
// tb/tb_car_motion_ctrl.sv - directed and randomized bench for car_motion_ctrl with a floor-level reference model
module tb_car_motion_ctrl;
    localparam int N = 4;
    localparam logic [1:0] UP = 2'b10, DN = 2'b01, ST = 2'b00;

    logic       clk = 1'b0;
    logic       reset = 1'b1, enable = 1'b1, doorState = 1'b0;
    logic [9:1] internalButton = '0;
    logic [7:1] upButton = '0, downButton = '0;
    logic [2:0] currentFloor;
    logic [1:0] currentDirection, currentFloorButton;
    logic       moving;
    logic [7:1] cabPend, upPend, downPend;

    int checks = 0, passes = 0, fails = 0;

    // Reference model: floor number, direction, remaining travel, activity phase
    // (0 idle, 1 travelling, 2 waiting for door open, 3 waiting for door close).
    int         m_floor, m_phase, m_cnt;
    logic [1:0] m_dir;
    logic [7:1] m_cab, m_up, m_down;

    car_motion_ctrl #(.CLK_PER_FLOOR(N)) dut (
        .clk(clk), .reset(reset), .enable(enable), .doorState(doorState),
        .internalButton(internalButton), .upButton(upButton), .downButton(downButton),
        .currentFloor(currentFloor), .currentDirection(currentDirection),
        .currentFloorButton(currentFloorButton), .moving(moving),
        .cabPend(cabPend), .upPend(upPend), .downPend(downPend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) begin
            passes++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit req_in(input int lo, input int hi);
        for (int f = lo; f <= hi; f++) begin
            if (f >= 1 && f <= 7 && (m_cab[f] || m_up[f] || m_down[f])) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        logic [7:1] nc, nu, nd;
        int nf;
        bit fur;
        if (reset) begin
            m_floor = 1; m_phase = 0; m_cnt = 0; m_dir = ST;
            m_cab = '0; m_up = '0; m_down = '0;
            return;
        end
        if (!enable) return;
        for (int f = 1; f <= 7; f++) begin
            nc[f] = m_cab[f] | internalButton[f];
            nu[f] = m_up[f] | ((f < 7) && upButton[f]);
            nd[f] = m_down[f] | ((f > 1) && downButton[f]);
        end
        if ((m_phase == 2 || m_phase == 3) && doorState) begin
            nc[m_floor] = 1'b0;
            if (m_dir == UP) nu[m_floor] = 1'b0;
            if (m_dir == DN) nd[m_floor] = 1'b0;
        end
        case (m_phase)
            0: begin
                if (req_in(m_floor, m_floor)) begin
                    if (m_dir != ST && (m_cab[m_floor] || (m_dir == UP ? m_up[m_floor] : m_down[m_floor]))) begin
                        m_dir = m_dir;
                    end else if (m_up[m_floor]) m_dir = UP;
                    else if (m_down[m_floor]) m_dir = DN;
                    else m_dir = (m_floor == 7) ? DN : UP;
                    m_phase = 2;
                end else if (req_in(m_floor + 1, 7) || req_in(1, m_floor - 1)) begin
                    if (m_dir == DN) m_dir = req_in(1, m_floor - 1) ? DN : UP;
                    else m_dir = req_in(m_floor + 1, 7) ? UP : DN;
                    m_cnt = N; m_phase = 1;
                end else begin
                    m_dir = ST;
                end
            end
            1: begin
                if (m_cnt == 1) begin
                    nf = m_floor + ((m_dir == UP) ? 1 : -1);
                    fur = (m_dir == UP) ? req_in(nf + 1, 7) : req_in(1, nf - 1);
                    m_floor = nf;
                    if (m_cab[nf] || (m_dir == UP ? m_up[nf] : m_down[nf])) m_phase = 2;
                    else if (!fur && (m_up[nf] || m_down[nf])) begin
                        m_dir = m_up[nf] ? UP : DN; m_phase = 2;
                    end else if (!fur) m_phase = 0;
                    else m_cnt = N;
                end else begin
                    m_cnt = m_cnt - 1;
                end
            end
            2: if (doorState) m_phase = 3;
            default: if (!doorState) m_phase = 0;
        endcase
        m_cab = nc; m_up = nu; m_down = nd;
    endtask

    // One clock: advance the model on the inputs presented, then compare after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("floor", 32'(currentFloor), 32'(m_floor));
        check("dir", 32'(currentDirection), 32'(m_dir));
        check("moving", 32'(moving), 32'(m_phase == 1));
        check("cabPend", 32'(cabPend), 32'(m_cab));
        check("upPend", 32'(upPend), 32'(m_up));
        check("downPend", 32'(downPend), 32'(m_down));
        check("floorButton", 32'(currentFloorButton), 32'({m_up[m_floor], m_down[m_floor]}));
    endtask

    task automatic wait_stop(input int f, input string tag);
        bit seen, done;
        seen = 0; done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            tick();
            if (moving) seen = 1;
            else if (seen && currentFloor == 3'(f)) done = 1;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1; tick(); reset = 1'b0;
    endtask

    initial begin
        // Reset with a press held during reset: not latched.
        reset = 1'b1; internalButton[3] = 1'b1;
        tick(); tick();
        reset = 1'b0; internalButton = '0;
        check("rst_floor", 32'(currentFloor), 32'd1);
        check("rst_dir", 32'(currentDirection), 32'(ST));
        check("rst_moving", 32'(moving), 32'd0);
        check("rst_cab", 32'(cabPend), 32'd0);

        // Cab call to floor 4: arrival timing at +5/+9/+13 from the latching edge.
        internalButton[4] = 1'b1; tick(); internalButton = '0;
        check("cab4_latched", 32'(cabPend), 32'h08);
        tick();
        check("go_dir", 32'(currentDirection), 32'(UP));
        check("go_moving", 32'(moving), 32'd1);
        repeat (3) tick();
        tick(); check("floor2_at5", 32'(currentFloor), 32'd2);
        repeat (4) tick(); check("floor3_at9", 32'(currentFloor), 32'd3);
        repeat (4) tick(); check("floor4_at13", 32'(currentFloor), 32'd4);
        check("stop4_moving", 32'(moving), 32'd0);
        doorState = 1'b1; repeat (3) tick();
        check("cab4_cleared", 32'(cabPend), 32'd0);
        doorState = 1'b0; tick(); tick();
        check("idle_dir_stop", 32'(currentDirection), 32'(ST));

        // Intermediate hall stop, overshoot past opposite call, then reverse to it.
        do_reset();
        internalButton[6] = 1'b1; upButton[3] = 1'b1; downButton[5] = 1'b1;
        tick();
        internalButton = '0; upButton = '0; downButton = '0;
        wait_stop(3, "stop_at3");
        doorState = 1'b1; tick();
        check("up3_cleared", 32'(upPend), 32'd0);
        check("down5_kept", 32'(downPend), 32'h10);
        doorState = 1'b0; tick();
        wait_stop(6, "stop_at6");
        check("dir_at6", 32'(currentDirection), 32'(UP));
        doorState = 1'b1; tick(); doorState = 1'b0; tick();
        wait_stop(5, "stop_at5");
        check("dir_at5", 32'(currentDirection), 32'(DN));
        doorState = 1'b1; tick();
        check("down5_cleared", 32'(downPend), 32'd0);
        doorState = 1'b0; tick();

        // Down call at the top floor: direction flips on arrival.
        do_reset();
        downButton[7] = 1'b1; tick(); downButton = '0;
        wait_stop(7, "stop_at7");
        check("flip_dir7", 32'(currentDirection), 32'(DN));
        check("fbtn7", 32'(currentFloorButton), 32'b01);
        doorState = 1'b1; tick();
        check("down7_cleared", 32'(downPend), 32'd0);
        check("fbtn7_clr", 32'(currentFloorButton), 32'b00);
        doorState = 1'b0; tick();

        // Enable freeze mid-move keeps the remaining travel count.
        do_reset();
        internalButton[3] = 1'b1; tick(); internalButton = '0;
        tick(); tick(); tick();
        enable = 1'b0; upButton[5] = 1'b1;
        repeat (10) tick();
        check("frz_floor", 32'(currentFloor), 32'd1);
        check("frz_up", 32'(upPend), 32'd0);
        check("frz_moving", 32'(moving), 32'd1);
        upButton = '0; enable = 1'b1;
        tick(); check("resume_floor1", 32'(currentFloor), 32'd1);
        tick(); check("resume_floor2", 32'(currentFloor), 32'd2);

        // Reset in the middle of travel above floor 5.
        do_reset();
        internalButton[7] = 1'b1; tick(); internalButton = '0;
        for (int i = 0; i < 100 && currentFloor != 3'd5; i++) tick();
        check("reach5", 32'(currentFloor), 32'd5);
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("mid_rst_floor", 32'(currentFloor), 32'd1);
        check("mid_rst_moving", 32'(moving), 32'd0);
        check("mid_rst_cab", 32'(cabPend), 32'd0);
        check("mid_rst_dir", 32'(currentDirection), 32'(ST));

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom % 300) == 0;
            enable = ($urandom % 10) != 0;
            doorState = ($urandom % 3) == 0;
            internalButton = '0; upButton = '0; downButton = '0;
            if ($urandom % 12 == 0) begin
                case ($urandom % 3)
                    0: internalButton[$urandom_range(9, 1)] = 1'b1;
                    1: upButton[$urandom_range(7, 1)] = 1'b1;
                    default: downButton[$urandom_range(7, 1)] = 1'b1;
                endcase
            end
            tick();
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/car_motion_ctrl.md
Name: car_motion_ctrl

Overview:
- Car-side motion controller for the 2-way, 7-floor elevator. It is the producer end of the door interface.
- Latches cabin and hall calls, then moves the car floor by floor with a timed travel counter.
- Drives currentFloor, currentDirection and currentFloorButton to the door controller, plus `moving`, which wires to the door's reset.
- Reads doorState back to know when a stop has been served and when the car may leave.

Parameters:
- CLK_PER_FLOOR, 1000000000, clk cycles of travel between adjacent floors; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- enable  in  1  clock enable; when 0, all state holds
- doorState  in  1  1 = OPEN, 0 = CLOSE (from door controller)
- internalButton  in  [9:1]  cabin buttons; bits 7..1 are floor calls (level, sampled each cycle); bits 9/8 are open/close and are ignored here
- upButton  in  [7:1]  hall up calls; bit 7 is ignored
- downButton  in  [7:1]  hall down calls; bit 1 is ignored
- currentFloor  out  3  floor 1..7
- currentDirection  out  2  STOP=00, UP=10, DOWN=01; 11 is never driven
- currentFloorButton  out  2  {upPend[currentFloor], downPend[currentFloor]}
- moving  out  1  1 while travelling; drives the door reset
- cabPend  out  [7:1]  latched cabin calls
- upPend  out  [7:1]  latched hall up calls
- downPend  out  [7:1]  latched hall down calls

Behaviour:
- Reset values:
  - currentFloor=1, currentDirection=STOP, moving=0, all Pend=0, counter=0, state=IDLE.
  - Reset mid-travel aborts the move with no intermediate floor.
- Enable: with enable=0, nothing changes. This includes latching and the counter.
- Latching:
  - Each enabled cycle, Pend |= button; ignored bits stay 0.
  - The clear rule below wins over a simultaneous set on the same bit.
- Clear rule: in DOOR with doorState=1, clear cabPend[currentFloor] and the hall bit matching currentDirection at currentFloor. The other hall bit stays.
- "Above" means any Pend bit at floors > currentFloor; "below" means any at floors < currentFloor. "Here" means any Pend bit at currentFloor.
- Direction choice, in priority order:
  - Keep the current direction if there are requests that way.
  - Otherwise reverse if there are requests the other way.
  - From STOP, prefer UP.
- FSM states:
  - IDLE (moving=0):
    - If here: set currentDirection:
      - keep a non-STOP direction when cabPend here or that direction's hall bit here;
      - else UP if upPend here;
      - else DOWN if downPend here;
      - from STOP with only a cab call: UP, or DOWN at floor 7.
      Then go to DOOR.
    - Else if above/below: set the direction by the choice rule, counter=CLK_PER_FLOOR, moving=1, go to MOVE.
    - Else currentDirection=STOP.
  - MOVE (moving=1):
    - counter decrements each enabled cycle.
    - When counter==1, on the next cycle: currentFloor ±1 per direction, then evaluate the stop at the new floor.
    - Stop if cabPend there, or the hall bit in the travel direction is set there, or (there are no requests further in the travel direction and any hall bit is set there).
    - In the last case, currentDirection flips to match that hall bit before stopping.
    - On stop: moving=0, go to DOOR. Otherwise reload counter=CLK_PER_FLOOR.
    - currentFloor never leaves 1..7: at 7 UP, or at 1 DOWN, always stops or reverses.
  - DOOR (moving=0):
    - Wait for doorState=1, applying the clear rule on each such cycle.
    - Then wait for doorState=0, then go to IDLE.
    - Door-open latency is not bounded here; the FSM waits indefinitely.
- currentFloorButton is combinational from the Pend registers and currentFloor.
- Transitions take effect one cycle after the enabling condition.

Test Plan:
- CLK_PER_FLOOR=4, reset 2 cycles → floor=1, direction=00, moving=0, all Pend=0; a press during reset is not latched.
- Idle at 1, pulse internalButton[4] → direction=10, moving=1; floor becomes 2/3/4 at cycles +5/+9/+13; at 4 moving=0; with doorState=1 held 3 cycles, cabPend[4] clears; after doorState=0 → IDLE, direction=00.
- While going up past 3, upButton[3] set before arrival at 3 and downButton[5] set, with cab at 6 → stops at 3 (then clears upPend[3]), stops at 6, then reverses to 5 with direction=01 and stops; downPend[5] clears.
- At floor 1 idle, only downButton[7] → travels to 7, flips direction to 01 on arrival, currentFloorButton=01, door opens, downPend[7] clears.
- enable=0 for 10 cycles mid-MOVE → floor, counter and Pend frozen; resumes with the exact remaining count.
- Reset asserted at floor 5 mid-move → next cycle floor=1, moving=0, Pend=0, state=IDLE.
